// File: rtl/lut_writer.sv
// ---------------------------------------------------------------------------
// lut_writer
//
// Loads one full lookup table (DEPTH words) from a valid/ready sample stream
// into an external RAM write port. A pass starts on a start pulse, accepts
// one sample per handshake, and writes each sample one cycle later at an
// incrementing address. While it runs it keeps a wrapping checksum of the
// words and a count of the words accepted.
//
// Ports:
//   clock         single clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   start         1-cycle pulse, begins a pass when idle
//   abort         ends an active pass early; partial results are kept
//   s_data        incoming sample
//   s_valid       s_data is valid
//   s_ready       block accepts s_data this cycle
//   wr_en         RAM write strobe
//   wr_addr       RAM write address
//   wr_data       RAM write data
//   busy          a pass is in progress (LOAD or DONE)
//   done          1-cycle pulse, the pass completed all DEPTH words
//   checksum      sum of the words in the current/last pass, mod 2^DATA_W
//   words_loaded  words accepted in the current/last pass
// ---------------------------------------------------------------------------
module lut_writer #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address of the final word in a pass. The counter is reset to 0
  // explicitly after it, so DEPTH does not have to be a power of two.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              xfer;

  // Ready depends on abort as well as state, so an aborting cycle can never
  // also accept a sample.
  assign s_ready = (state == LOAD) && !abort;
  assign xfer    = s_valid && s_ready;

  // Single state machine that also owns every registered output. wr_en
  // defaults low each cycle so that it pulses only in the cycle after a
  // transfer. wr_addr/wr_data keep their last value between writes. busy
  // and done are registered from the next state rather than decoded from
  // the state register, so they come straight from flops and do not glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      counter      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      checksum     <= '0;
      words_loaded <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= LOAD;
            busy         <= 1'b1;
            counter      <= '0;
            checksum     <= '0;
            words_loaded <= '0;
          end
        end

        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (xfer) begin
            wr_en        <= 1'b1;
            wr_addr      <= counter;
            wr_data      <= s_data;
            checksum     <= checksum + s_data;
            words_loaded <= words_loaded + 1'b1;
            if (counter == LAST_ADDR) begin
              // The last write and the done pulse share the same cycle.
              counter <= '0;
              state   <= DONE;
              done    <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lut_writer.md
LUT_WRITER -- requirements
Module: lut_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of LUT words loaded per pass.
REQ-002 SHALL have parameter ADDR_W, default 10, address width (clog2(DEPTH)).
REQ-003 SHALL have parameter DATA_W, default 16, sample width.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  1-cycle pulse; begins a load pass when idle.
REQ-007 abort  input  1  terminates an active pass.
REQ-008 s_data  input  DATA_W  incoming sample.
REQ-009 s_valid  input  1  s_data valid.
REQ-010 s_ready  output  1  block accepts s_data.
REQ-011 wr_en  output  1  RAM write strobe.
REQ-012 wr_addr  output  ADDR_W  RAM write address.
REQ-013 wr_data  output  DATA_W  RAM write data.
REQ-014 busy  output  1  pass in progress.
REQ-015 done  output  1  1-cycle pulse; pass completed.
REQ-016 checksum  output  DATA_W  mod-2^DATA_W sum of words in last pass.
REQ-017 words_loaded  output  ADDR_W+1  words accepted in current/last pass.

Function
REQ-018 SHALL implement states IDLE, LOAD, DONE in a registered state machine.
REQ-019 IDLE: start=1 -> LOAD next cycle; clear addr counter, checksum, words_loaded to 0.
REQ-020 start SHALL be ignored in LOAD and DONE.
REQ-021 s_ready SHALL equal (state==LOAD) AND NOT abort, combinational from state and abort.
REQ-022 Transfer SHALL occur on a rising edge where s_valid=1 and s_ready=1; s_valid without s_ready is no transfer.
REQ-023 On transfer: next cycle wr_en=1, wr_addr=counter, wr_data=s_data (one-cycle registered latency).
REQ-024 wr_en SHALL be 0 in every cycle not following a transfer; wr_addr/wr_data hold last value when wr_en=0.
REQ-025 On transfer: counter+1, words_loaded+1, checksum += s_data, wrapping mod 2^DATA_W.
REQ-026 Transfer with counter==DEPTH-1 SHALL move LOAD -> DONE; counter wraps to 0; no further transfers accepted.
REQ-027 DONE SHALL last exactly one cycle with done=1, then -> IDLE.
REQ-028 Final wr_en pulse (addr DEPTH-1) SHALL coincide with the done=1 cycle.
REQ-029 busy SHALL be 1 in LOAD and DONE, 0 in IDLE.
REQ-030 abort=1 in LOAD: no transfer that cycle, -> IDLE next cycle, done stays 0, checksum and words_loaded hold partial values.
REQ-031 abort SHALL be ignored in IDLE and DONE.
REQ-032 s_valid gaps SHALL stall the pass indefinitely without timeout.
REQ-033 checksum and words_loaded SHALL hold after DONE until next accepted start.

Reset
REQ-034 reset_n=0 SHALL asynchronously force state=IDLE, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, checksum=0, words_loaded=0, counter=0.
REQ-035 Reset mid-LOAD SHALL abandon the pass with no wr_en or done pulse after release; first post-reset start begins a fresh pass from address 0.

Verification
REQ-036 Full pass, s_valid held 1, s_data=addr: 1024 wr_en pulses, addresses 0..1023 in order, done on cycle of last write, checksum=0xFE00 (sum 0..1023 mod 2^16), words_loaded=1024.
REQ-037 Random s_valid gaps, DEPTH=1024: identical write sequence and checksum to gap-free run; busy=1 throughout; no wr_en in gap cycles.
REQ-038 abort after 10 transfers with s_valid=1 same cycle: exactly 10 writes (addr 0..9), done never pulses, words_loaded=10, s_ready=0 that cycle.
REQ-039 start pulses during LOAD and DONE: no restart, counter continuity preserved; start in IDLE after done: words_loaded/checksum clear, writes restart at 0.
REQ-040 reset_n low for 1 cycle at transfer 500: all outputs 0 immediately, no further writes; subsequent pass completes normally with DEPTH writes.
REQ-041 Checksum wrap, s_data=0xFFFF every word: checksum=0xFC00 (1024 × 0xFFFF mod 2^16).
